ternary_sample_ctrl: RTL
========================

# ternary_sample_ctrl

Sequencer for the ternary sampling stage of encapsulation. Pulls 16-bit random words from the RNG over a valid/ready handshake and feeds them one word per beat to the mod-3 sampler/SIPO. It clears the SIPO before each run, counts exactly NUM_WORDS transfers (each word yields two ternary coefficients, 4 SIPO bits), and reports completion once the 2800-bit r‖m vector is fully loaded.

## Interface
- RANDOM_BITS, 16, width of one RNG word and of samp_bits
- NUM_WORDS, 700, words per run (RM_BITS/4 = 2800/4)
- CNT_W, 10, width of word_cnt; must satisfy 2^CNT_W > NUM_WORDS
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled in IDLE or DONE only
- abort  in  1  cancel the current run; effective in CLEAR, FILL, LAST
- rnd_valid  in  1  RNG word available
- rnd_data  in  RANDOM_BITS  RNG word
- rnd_ready  out  1  controller accepts rnd_data this cycle
- samp_clr  out  1  one-cycle clear pulse to the sampler SIPO
- samp_en  out  1  sampler shift enable; one pulse per accepted word
- samp_bits  out  RANDOM_BITS  word presented to the sampler, valid while samp_en=1
- word_cnt  out  CNT_W  number of words accepted in the current run
- busy  out  1  high in CLEAR, FILL, LAST
- done  out  1  high in DONE; SIPO holds a complete vector

## Operation
- States: IDLE, CLEAR, FILL, LAST, DONE. All outputs registered except rnd_ready.
- Reset (rst=1 at posedge): state IDLE; busy=0, done=0, samp_clr=0, samp_en=0, samp_bits=0, word_cnt=0. rnd_ready=0 combinationally.
- IDLE: start=1 → CLEAR. Otherwise hold.
- CLEAR (one cycle): samp_clr=1, busy=1, word_cnt=0, done=0. Next state FILL unless abort.
- FILL: rnd_ready = (state==FILL) & ~abort. A transfer is rnd_valid & rnd_ready at a posedge: samp_bits <= rnd_data, samp_en <= 1, word_cnt <= word_cnt+1. No transfer: samp_en <= 0, samp_bits holds. Transfer with word_cnt==NUM_WORDS-1 → LAST.
- LAST (one cycle): samp_en=1 carrying the final word; rnd_ready=0. Next state DONE.
- DONE: done=1, busy=0, samp_en=0, word_cnt=NUM_WORDS held. start=1 → CLEAR (restart, done drops next cycle). Otherwise hold.
- abort=1 in CLEAR/FILL/LAST: next state IDLE, samp_en=0, done=0, no transfer that cycle. word_cnt holds its value; the SIPO content is partial and is not reported done.
- start while busy is ignored. start and abort together in IDLE/DONE: start wins (abort has no effect outside busy states).
- rst overrides everything, including mid-run; outputs take reset values at the next posedge.
- word_cnt never exceeds NUM_WORDS; never wraps.

## Timing
- Cycle 0: start sampled. Cycle 1: CLEAR, samp_clr=1. Cycle 2: FILL, rnd_ready=1.
- rnd_valid held high: transfers at end of cycles 2..701, samp_en=1 in cycles 3..702 (cycle 702 = LAST), done=1 from cycle 703. Total start-to-done: 703 cycles.
- Each RNG stall cycle (rnd_valid=0 in FILL) delays done by exactly one cycle and produces one samp_en=0 bubble.
- samp_en follows its accepting transfer by one cycle; samp_bits stable for the whole samp_en cycle.
- samp_clr and samp_en never high in the same cycle.

## Test plan
- Reset: rst=1 for 2 cycles mid-FILL → all outputs 0, state IDLE; rnd_ready=0 immediately after.
- Full run, rnd_valid constant 1, rnd_data = incrementing counter from 0 → samp_clr at cycle 1, exactly 700 samp_en pulses with samp_bits 0..699 in order, done=1 at cycle 703, word_cnt=700.
- Stalled run: rnd_valid low every third cycle → still 700 pulses in order, done delayed by the number of stall cycles, no data lost or duplicated.
- Abort at word_cnt=350 → next cycle IDLE, busy=0, done=0, no further samp_en; a following start gives samp_clr then a clean 700-word run.
- Start while busy (at word_cnt=100) → ignored, run completes normally; start in DONE → done drops, new samp_clr next cycle.
- Integrated with sampler + reference mod-3 model: final 2800-bit vector matches golden model and the sampler's own done agrees with controller done at cycle 703.

Source files
------------

// File: rtl/ternary_sample_ctrl.sv
// Purpose: sequences one ternary sampling run by clearing the SIPO, then moving NUM_WORDS RNG words into the sampler.
// Latency: start is followed by samp_clr 1 cycle later and rnd_ready 2 cycles later; done is up 703 cycles after start if the RNG never stalls.
// Backpressure: rnd_ready is high only in FILL without abort; each RNG stall cycle adds one samp_en bubble and pushes done out one cycle.
module ternary_sample_ctrl #(
    parameter int RANDOM_BITS = 16,
    parameter int NUM_WORDS   = 700,
    parameter int CNT_W       = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   rnd_valid,
    input  logic [RANDOM_BITS-1:0] rnd_data,
    output logic                   rnd_ready,
    output logic                   samp_clr,
    output logic                   samp_en,
    output logic [RANDOM_BITS-1:0] samp_bits,
    output logic [CNT_W-1:0]       word_cnt,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FILL  = 3'd2,
        ST_LAST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Count value held by the word that moves the run into LAST.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic                   xfer;
    logic                   samp_clr_nxt;
    logic                   samp_en_nxt;
    logic [RANDOM_BITS-1:0] samp_bits_nxt;
    logic [CNT_W-1:0]       word_cnt_nxt;
    logic                   busy_nxt;
    logic                   done_nxt;

    // rnd_ready is the only combinational output. Abort masks it right away, so no word is taken in the cycle the run is cancelled.
    assign rnd_ready = (state == ST_FILL) & ~abort;
    assign xfer      = rnd_valid & rnd_ready;

    // Next-state and next-output decode. Every registered output is derived from the state being entered.
    always_comb begin
        state_nxt     = state;
        samp_clr_nxt  = 1'b0;
        samp_en_nxt   = 1'b0;
        samp_bits_nxt = samp_bits;
        word_cnt_nxt  = word_cnt;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (xfer) begin
                    samp_en_nxt   = 1'b1;
                    samp_bits_nxt = rnd_data;
                    word_cnt_nxt  = word_cnt + 1'b1;
                    if (word_cnt == LAST_IDX) begin
                        state_nxt = ST_LAST;
                    end
                end
            end
            ST_LAST: begin
                // The final word is already on samp_bits/samp_en during this cycle.
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_CLEAR;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Entering CLEAR always starts a fresh count. This also covers a restart from DONE.
        if (state_nxt == ST_CLEAR) begin
            samp_clr_nxt = 1'b1;
            word_cnt_nxt = '0;
        end

        busy_nxt = (state_nxt == ST_CLEAR) || (state_nxt == ST_FILL) || (state_nxt == ST_LAST);
        done_nxt = (state_nxt == ST_DONE);
    end

    // State register with its registered outputs. Synchronous reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            samp_clr  <= 1'b0;
            samp_en   <= 1'b0;
            samp_bits <= '0;
            word_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            samp_clr  <= samp_clr_nxt;
            samp_en   <= samp_en_nxt;
            samp_bits <= samp_bits_nxt;
            word_cnt  <= word_cnt_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule
